pc_sequencer: RTL and testbench

Fetch-control sequencer that drives the 8-bit program counter's `Enable_PC`, `Update_PC` and `New_Address` controls. It tracks validity of the three in-flight slots (PC, PC_D1, PC_D2) and handles start, stall, taken branch, halt and interrupt entry. It sits between the decode/execute control logic and the program counter. It is the only block allowed to redirect the PC.

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-control sequencer: drives the program counter's increment/load controls
// and tracks validity of the PC, D1 and D2 pipeline slots.
module pc_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter logic [7:0] IRQ_VECTOR   = 8'hF0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] start_addr,
    input  logic       stall,
    input  logic       br_valid,
    input  logic [7:0] br_target,
    input  logic       halt,
    input  logic       irq,
    input  logic       irq_en,
    input  logic [7:0] pc,
    input  logic [7:0] pc_d1,
    output logic       Enable_PC,
    output logic       Update_PC,
    output logic [7:0] New_Address,
    output logic       flush,
    output logic [2:0] valid,
    output logic       irq_ack,
    output logic [7:0] epc,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [2:0] valid_next;
    logic [7:0] epc_next;
    logic       irq_entry;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        Enable_PC   = 1'b0;
        Update_PC   = 1'b0;
        New_Address = RESET_VECTOR;
        flush       = 1'b0;
        state_next  = state;
        valid_next  = valid;
        epc_next    = epc;
        irq_entry   = 1'b0;

        // While reset is held the PC is pinned to the reset vector regardless of inputs.
        if (!rst_n) begin
            Update_PC  = 1'b1;
            valid_next = 3'b000;
        end else begin
            unique case (state)
                IDLE: begin
                    Update_PC = 1'b1;
                    if (start) begin
                        New_Address = start_addr;
                        state_next  = RUN;
                        valid_next  = 3'b001;
                    end else begin
                        valid_next  = 3'b000;
                    end
                end
                RUN: begin
                    if (br_valid && valid[2]) begin
                        Update_PC   = 1'b1;
                        New_Address = br_target;
                        flush       = 1'b1;
                        valid_next  = 3'b001;
                    end else if (halt && valid[2]) begin
                        // pc_d1 holds the address just after the halting instruction.
                        Update_PC   = 1'b1;
                        New_Address = pc_d1;
                        flush       = 1'b1;
                        state_next  = HALTED;
                        valid_next  = 3'b000;
                    end else if (irq && irq_en) begin
                        Update_PC   = 1'b1;
                        New_Address = IRQ_VECTOR;
                        flush       = 1'b1;
                        valid_next  = 3'b001;
                        irq_entry   = 1'b1;
                        epc_next    = valid[1] ? pc_d1 : pc;
                    end else if (stall) begin
                        valid_next  = {valid[1], 1'b0, valid[0]};
                    end else begin
                        Enable_PC   = 1'b1;
                        valid_next  = {valid[1], valid[0], 1'b1};
                    end
                end
                HALTED: begin
                    if (irq && irq_en) begin
                        Update_PC   = 1'b1;
                        New_Address = IRQ_VECTOR;
                        flush       = 1'b1;
                        state_next  = RUN;
                        valid_next  = 3'b001;
                        irq_entry   = 1'b1;
                        epc_next    = pc;
                    end else if (start) begin
                        Update_PC   = 1'b1;
                        New_Address = start_addr;
                        state_next  = RUN;
                        valid_next  = 3'b001;
                    end else begin
                        valid_next  = {valid[1], valid[0], 1'b0};
                    end
                end
                default: begin
                    Update_PC  = 1'b1;
                    state_next = IDLE;
                    valid_next = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid   <= 3'b000;
            epc     <= 8'h00;
            irq_ack <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state   <= state_next;
            valid   <= valid_next;
            epc     <= epc_next;
            irq_ack <= irq_entry;
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; includes a small program-counter model
// that obeys Enable_PC / Update_PC so redirects can be followed end to end.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stall, br_valid, halt, irq, irq_en;
    logic [7:0] start_addr, br_target;
    logic [7:0] pc, pc_d1;
    logic       Enable_PC, Update_PC, flush, irq_ack, running;
    logic [7:0] New_Address, epc;
    logic [2:0] valid;

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .br_valid(br_valid), .br_target(br_target), .halt(halt),
        .irq(irq), .irq_en(irq_en), .pc(pc), .pc_d1(pc_d1),
        .Enable_PC(Enable_PC), .Update_PC(Update_PC), .New_Address(New_Address),
        .flush(flush), .valid(valid), .irq_ack(irq_ack), .epc(epc), .running(running)
    );

    always #5 clk = ~clk;

    // Program counter: no reset of its own, obeys the sequencer controls.
    always @(posedge clk) begin
        pc_d1 <= pc;
        if (Update_PC)      pc <= New_Address;
        else if (Enable_PC) pc <= pc + 8'd1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic en, input logic upd,
                           input logic [7:0] na, input logic fl);
        check({tag, ".en"},    8'(Enable_PC), 8'(en));
        check({tag, ".upd"},   8'(Update_PC), 8'(upd));
        if (upd) check({tag, ".na"}, New_Address, na);
        check({tag, ".flush"}, 8'(flush), 8'(fl));
    endtask

    task automatic chk_pc(input string tag, input logic [7:0] exp_pc, input logic [2:0] exp_v);
        check({tag, ".pc"},    pc, exp_pc);
        check({tag, ".valid"}, 8'(valid), 8'(exp_v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; start_addr = 8'h10; stall = 1'b0;
        br_valid = 1'b0; br_target = 8'h00; halt = 1'b0; irq = 1'b1; irq_en = 1'b1;
        #2;
        // Reset state, with start and irq asserted to confirm they are ignored.
        chk_ctl("rst", 1'b0, 1'b1, 8'h00, 1'b0);
        check("rst.valid",   8'(valid), 8'h00);
        check("rst.running", 8'(running), 8'h00);
        check("rst.irq_ack", 8'(irq_ack), 8'h00);
        check("rst.epc",     epc, 8'h00);
        start = 1'b0; irq = 1'b0; irq_en = 1'b0;
        tick();
        tick();
        check("rst.pc", pc, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        #1 chk_ctl("idle", 1'b0, 1'b1, 8'h00, 1'b0);

        // Start at 0x10 and fill the pipeline.
        start = 1'b1; start_addr = 8'h10;
        #1 chk_ctl("start", 1'b0, 1'b1, 8'h10, 1'b0);
        tick(); start = 1'b0;
        check("start.running", 8'(running), 8'h01);
        chk_pc("run0", 8'h10, 3'b001);
        tick(); chk_pc("run1", 8'h11, 3'b011);
        tick(); chk_pc("run2", 8'h12, 3'b111);
        tick(); chk_pc("run3", 8'h13, 3'b111);

        // start while running is ignored.
        start = 1'b1; start_addr = 8'h77;
        #1 chk_ctl("start_in_run", 1'b1, 1'b0, 8'h00, 1'b0);
        tick(); start = 1'b0;
        check("start_in_run.pc", pc, 8'h14);
        repeat (12) tick();
        chk_pc("pre_stall", 8'h20, 3'b111);

        // Two-cycle stall at 0x20.
        stall = 1'b1;
        #1 chk_ctl("stall", 1'b0, 1'b0, 8'h00, 1'b0);
        tick(); chk_pc("stall1", 8'h20, 3'b101);
        tick(); chk_pc("stall2", 8'h20, 3'b001);
        stall = 1'b0;
        tick(); chk_pc("resume1", 8'h21, 3'b011);
        tick(); chk_pc("resume2", 8'h22, 3'b111);

        // Taken branch with stall also high: stall is ignored.
        stall = 1'b1; br_valid = 1'b1; br_target = 8'h40;
        #1 chk_ctl("branch", 1'b0, 1'b1, 8'h40, 1'b1);
        tick(); stall = 1'b0; br_valid = 1'b0;
        #1 check("branch.flush_off", 8'(flush), 8'h00);
        chk_pc("br0", 8'h40, 3'b001);

        // Branch and halt with valid[2]=0: no redirect.
        br_valid = 1'b1; halt = 1'b1; br_target = 8'h2E;
        #1 chk_ctl("br_halt_inv0", 1'b1, 1'b0, 8'h00, 1'b0);
        tick(); chk_pc("br1", 8'h41, 3'b011);
        chk_ctl("br_halt_inv1", 1'b1, 1'b0, 8'h00, 1'b0);
        tick(); chk_pc("br2", 8'h42, 3'b111);
        // With valid[2]=1 the branch wins over halt.
        chk_ctl("br_over_halt", 1'b0, 1'b1, 8'h2E, 1'b1);
        tick(); br_valid = 1'b0; halt = 1'b0;
        check("br_over_halt.running", 8'(running), 8'h01);
        chk_pc("br3", 8'h2E, 3'b001);
        repeat (4) tick();
        chk_pc("pre_halt", 8'h32, 3'b111);
        check("pre_halt.pc_d1", pc_d1, 8'h31);

        // Halt of the instruction at 0x30.
        halt = 1'b1;
        #1 chk_ctl("halt", 1'b0, 1'b1, 8'h31, 1'b1);
        tick(); halt = 1'b0;
        check("halt.running", 8'(running), 8'h00);
        chk_pc("halted0", 8'h31, 3'b000);
        #1 chk_ctl("halted", 1'b0, 1'b0, 8'h00, 1'b0);
        tick(); chk_pc("halted1", 8'h31, 3'b000);

        // irq with irq_en=0 has no effect.
        irq = 1'b1; irq_en = 1'b0;
        #1 chk_ctl("irq_masked", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("irq_masked.ack", 8'(irq_ack), 8'h00);
        check("irq_masked.running", 8'(running), 8'h00);
        check("irq_masked.pc", pc, 8'h31);

        // irq entry from HALTED.
        irq_en = 1'b1;
        #1 chk_ctl("irq_halted", 1'b0, 1'b1, 8'hF0, 1'b1);
        tick(); irq = 1'b0;
        check("irq_halted.ack", 8'(irq_ack), 8'h01);
        check("irq_halted.epc", epc, 8'h31);
        check("irq_halted.running", 8'(running), 8'h01);
        chk_pc("irq_halted", 8'hF0, 3'b001);
        tick();
        check("irq_ack_pulse", 8'(irq_ack), 8'h00);
        check("epc_hold", epc, 8'h31);
        chk_pc("irq_run1", 8'hF1, 3'b011);

        // irq entry from RUN with valid[1]=1: epc takes pc_d1.
        irq = 1'b1;
        #1 chk_ctl("irq_run", 1'b0, 1'b1, 8'hF0, 1'b1);
        tick(); irq = 1'b0;
        check("irq_run.ack", 8'(irq_ack), 8'h01);
        check("irq_run.epc", epc, 8'hF0);
        chk_pc("irq_run", 8'hF0, 3'b001);

        // Free run across the 8'hFF -> 8'h00 wrap.
        repeat (15) tick();
        chk_pc("wrap_ff", 8'hFF, 3'b111);
        tick(); chk_pc("wrap_00", 8'h00, 3'b111);
        repeat (8'h55) tick();
        chk_pc("pre_reset", 8'h55, 3'b111);

        // Asynchronous reset mid-run.
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("async_rst.valid",   8'(valid), 8'h00);
        check("async_rst.running", 8'(running), 8'h00);
        check("async_rst.epc",     epc, 8'h00);
        check("async_rst.pc_held", pc, 8'h55);
        chk_ctl("async_rst", 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        check("async_rst.pc", pc, 8'h00);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
